// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader
// Drains a show-ahead FIFO into an AXI4-Stream master. The output beat is
// registered, and a one-entry skid register absorbs the pop that was already
// committed when the consumer stalls. Because of the skid, fifo_r_en never
// depends on m_tready. Beats are grouped into fixed-length packets via
// m_tlast.
//
// Ports:
//   aclk, aresetn         clock / async active-low reset
//   enable                allow new pops (buffered beats drain regardless)
//   fifo_empty            FIFO empty flag
//   fifo_r_data           FIFO head word (show-ahead)
//   fifo_r_en             pop strobe to the FIFO
//   m_tdata/m_tvalid/
//   m_tlast/m_tready      AXI4-Stream master
//   pkt_count             count of accepted tlast beats (wraps)
//   busy                  output stage or skid register holds a beat
module fifo_axis_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_r_data,
  output logic             fifo_r_en,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy
);

  // Beat-position counter width; a 1-bit counter that never moves is used
  // when packets are disabled (0) or single-beat (1).
  localparam int            PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = (PKT_LEN > 1) ? PW'(PKT_LEN - 1) : '0;
  localparam bit            HAS_LAST = (PKT_LEN != 0);

  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PW-1:0]    pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic pop, pop_last, accept;

  // A pop is only issued when the skid is empty, so even if the output stage
  // stalls this very cycle there is room for the word. Held off during reset.
  assign pop      = aresetn & enable & ~fifo_empty & ~skid_valid_q;
  assign pop_last = HAS_LAST && (pop_cnt_q == LAST_IDX);
  assign accept   = tvalid_q & m_tready;

  always_comb begin
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    pop_cnt_d    = pop_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;

    if (pop && (!tvalid_q || accept)) begin
      // Output stage free: popped word goes straight to the output.
      tdata_d  = fifo_r_data;
      tlast_d  = pop_last;
      tvalid_d = 1'b1;
    end else if (pop) begin
      // Output stalled: park the word; skid is known empty here.
      skid_data_d  = fifo_r_data;
      skid_last_d  = pop_last;
      skid_valid_d = 1'b1;
    end else if (accept && skid_valid_q) begin
      // Refill the output from the skid, preserving order.
      tdata_d      = skid_data_q;
      tlast_d      = skid_last_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      tvalid_d = 1'b0;
    end

    if (pop && (PKT_LEN > 1))
      pop_cnt_d = (pop_cnt_q == LAST_IDX) ? '0 : pop_cnt_q + PW'(1);

    if (accept && tlast_q)
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      pop_cnt_q    <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      pop_cnt_q    <= pop_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign fifo_r_en = pop;
  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign pkt_count = pkt_cnt_q;
  assign busy      = tvalid_q | skid_valid_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader. Four instances (PKT_LEN 4, 16, 1, 0) share one
// FIFO model and one stream-ready; pops are independent of PKT_LEN, so all
// instances move in lock step and differ only in tlast/pkt_count.
module tb_fifo_axis_reader;

  localparam int N = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_r_data = 8'h00;
  logic       m_tready = 1'b0;

  logic [N-1:0] r_en, tvalid, tlast, busy;
  logic [7:0]   tdata [N];
  logic [15:0]  pcnt  [N];

  always #5 aclk = ~aclk;

  function automatic int plen(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : (k == 2) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 1 : 0;
    fifo_axis_reader #(.WIDTH(8), .PKT_LEN(L), .CNT_W(16)) u_dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_r_data(fifo_r_data),
      .fifo_r_en  (r_en[g]),
      .m_tdata    (tdata[g]),
      .m_tvalid   (tvalid[g]),
      .m_tlast    (tlast[g]),
      .m_tready   (m_tready),
      .pkt_count  (pcnt[g]),
      .busy       (busy[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct packed {
    logic [7:0]   d;
    logic [N-1:0] last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] fifo_q[$];
  int pop_idx = 0, pops = 0, accs = 0, cyc = 0;
  int first_pop = -1, last_pop = -1, first_vld = -1;
  int pkt_exp [N];
  bit pop_pend = 0;
  bit held = 0;
  logic [7:0]   hd [N];
  logic [N-1:0] hl;

  // FIFO model: the pop seen at the previous falling edge happens here.
  always @(posedge aclk) begin
    if (pop_pend) begin
      pop_pend = 0;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty  <= (fifo_q.size() == 0);
      fifo_r_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    beat_t e, b;
    cyc++;
    if (aresetn) begin
      if (held)
        for (int k = 0; k < N; k++) begin
          chk("hold_valid", tvalid[k], 1);
          chk("hold_data", tdata[k], hd[k]);
          chk("hold_last", tlast[k], hl[k]);
        end
      if (tvalid[0] && m_tready) begin
        if (sb.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          e = sb.pop_front();
          for (int k = 0; k < N; k++) begin
            chk("beat_data", tdata[k], e.d);
            chk("beat_last", tlast[k], e.last[k]);
            if (e.last[k]) pkt_exp[k]++;
          end
        end
        accs++;
      end
      if (first_vld < 0 && tvalid[0]) first_vld = cyc;
      held = tvalid[0] && !m_tready;
      for (int k = 0; k < N; k++) hd[k] = tdata[k];
      hl = tlast;
      if (r_en[0]) begin
        b.d = fifo_r_data;
        for (int k = 0; k < N; k++)
          b.last[k] = (plen(k) != 0) && ((pop_idx % plen(k)) == plen(k) - 1);
        sb.push_back(b);
        pop_idx++;
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pop_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_empty  = 1'b0;
    fifo_r_data = fifo_q[0];
  endtask

  task automatic clr_stats();
    pops = 0; accs = 0; first_pop = -1; last_pop = -1; first_vld = -1;
  endtask

  // Asserted mid-cycle so the checks see the asynchronous effect.
  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_valid", tvalid[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_pkt", pcnt[k], 0);
      chk("rst_ren", r_en[k], 0);
      chk("rst_last", tlast[k], 0);
      chk("rst_data", tdata[k], 0);
    end
    sb.delete();
    pop_idx = 0;
    held = 0;
    pop_pend = 0;
    for (int k = 0; k < N; k++) pkt_exp[k] = 0;
    tick();
    tick();
    aresetn = 1'b1;
    clr_stats();
  endtask

  task automatic drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !busy[0] && (fifo_q.size() == 0 || !enable)) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_pkts();
    for (int k = 0; k < N; k++) chk("pkt_model", pcnt[k], pkt_exp[k]);
  endtask

  initial begin
    for (int k = 0; k < N; k++) pkt_exp[k] = 0;
    enable = 1'b1;
    m_tready = 1'b1;
    tick();
    do_reset();

    // Basic 4-beat packet at full rate.
    for (int i = 1; i <= 4; i++) push(8'(i));
    drain(50);
    chk("t1_pops", pops, 4);
    chk("t1_back_to_back", last_pop - first_pop, 3);
    chk("t1_latency", first_vld - first_pop, 1);
    chk("t1_pkt", pcnt[0], 1);
    chk_pkts();

    // Stalled consumer: output + skid only, then ordered drain.
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (10) tick();
    chk("t2_pops", pops, 2);
    chk("t2_busy", busy[0], 1);
    chk("t2_ren", r_en[0], 0);
    chk("t2_fifo_left", fifo_q.size(), 6);
    m_tready = 1'b1;
    drain(100);
    chk("t2_beats", accs, 8);
    chk("t2_pkt", pcnt[0], 2);
    chk_pkts();

    // Random backpressure over 1000 beats.
    do_reset();
    for (int i = 0; i < 1000; i++) push(8'($urandom));
    for (int i = 0; i < 20000 && accs < 1000; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_tready = 1'b1;
    drain(50);
    chk("t3_beats", accs, 1000);
    chk("t3_pkt16", pcnt[1], 62);
    chk("t3_pkt4", pcnt[0], 250);
    chk("t3_pkt1", pcnt[2], 1000);
    chk("t3_pkt0", pcnt[3], 0);
    chk_pkts();

    // enable dropped after two pops of a packet.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 20 && pops < 2; i++) tick();
    enable = 1'b0;
    repeat (10) tick();
    chk("t4_pops_held", pops, 2);
    chk("t4_drained", accs, 2);
    chk("t4_idle", busy[0], 0);
    enable = 1'b1;
    drain(50);
    chk("t4_pops", pops, 4);
    chk("t4_pkt", pcnt[0], 1);
    chk_pkts();

    // Reset with output and skid both occupied.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    drain(50);
    chk("t5_pkt_pre", pcnt[0], 1);
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    repeat (5) tick();
    chk("t5_busy", busy[0], 1);
    chk("t5_valid", tvalid[0], 1);
    chk("t5_pops", pops, 6);
    do_reset();
    m_tready = 1'b1;
    drain(50);
    chk("t5_beats", accs, 6);
    chk("t5_pkt", pcnt[0], 1);
    chk("t5_pkt0", pcnt[3], 0);
    chk_pkts();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
